// File: rtl/cache_refill_seq_if.sv
// Memory-side word bus of the cache refill sequencer: one word per request/ack handshake.
interface cache_refill_seq_if #(
   parameter int unsigned ADDR_WID = 21
) ();
   logic                mem_req;
   logic                mem_we;
   logic [ADDR_WID-1:0] mem_addr;
   logic                mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      output mem_ack
   );
endinterface

// File: rtl/cache_refill_seq.sv
// Cache line refill sequencer: optional victim writeback burst, fill burst, tag commit, release.
// Writeback support is compiled in only when CACHE_WBACK_EN is defined.
module cache_refill_seq #(
   parameter int unsigned TAG_WID     = 14,
   parameter int unsigned WAYADDR_WID = 5,
   parameter int unsigned WAYSEL_WID  = 1,
   parameter int unsigned LINE_WORDS  = 4,
   localparam int unsigned OFS_WID    = $clog2(LINE_WORDS),
   localparam int unsigned MADDR_WID  = TAG_WID + WAYADDR_WID + OFS_WID
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   line_miss,
   input  logic                   replace_dirty,
   input  logic [TAG_WID-1:0]     miss_tag,
   input  logic [WAYADDR_WID-1:0] miss_ent,
   input  logic [TAG_WID-1:0]     victim_tag,
   input  logic [WAYSEL_WID-1:0]  way_replace_sel,
   cache_refill_seq_if.master     mem,
   output logic                   cache_wen,
   output logic [WAYSEL_WID-1:0]  cache_way,
   output logic [OFS_WID-1:0]     cache_word,
   output logic [TAG_WID-1:0]     refill_tag,
   output logic                   line_refill,
   output logic                   writeback_ok,
   output logic                   busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef CACHE_WBACK_EN
   localparam logic [2:0] S_WB      = 3'd1;
   localparam logic [2:0] S_WB_DONE = 3'd2;
`endif
   localparam logic [2:0] S_FILL    = 3'd3;
   localparam logic [2:0] S_COMMIT  = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   logic [2:0]             state, state_nxt;
   logic [OFS_WID-1:0]     cnt;
   logic [TAG_WID-1:0]     miss_tag_l;
   logic [WAYADDR_WID-1:0] miss_ent_l;
   logic [WAYSEL_WID-1:0]  way_l;
   logic                   ld_miss, cnt_inc, cnt_clr;
   logic                   req_c, we_c;
   logic                   last_word;

   assign last_word = (cnt == OFS_WID'(LINE_WORDS - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and control decode
   always_comb begin
      state_nxt    = state;
      ld_miss      = 1'b0;
      cnt_inc      = 1'b0;
      cnt_clr      = 1'b0;
      req_c        = 1'b0;
      we_c         = 1'b0;
      cache_wen    = 1'b0;
      line_refill  = 1'b0;
      writeback_ok = 1'b0;
      busy         = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (line_miss) begin
               ld_miss = 1'b1;
`ifdef CACHE_WBACK_EN
               state_nxt = replace_dirty ? S_WB : S_FILL;
`else
               state_nxt = S_FILL;
`endif
            end
         end
`ifdef CACHE_WBACK_EN
         S_WB: begin
            req_c = 1'b1;
            we_c  = 1'b1;
            if (mem.mem_ack) begin
               cnt_inc = 1'b1;
               if (last_word) state_nxt = S_WB_DONE;
            end
         end
         S_WB_DONE: begin
            writeback_ok = 1'b1;
            cnt_clr      = 1'b1;
            state_nxt    = S_FILL;
         end
`endif
         S_FILL: begin
            req_c     = 1'b1;
            cache_wen = mem.mem_ack;
            if (mem.mem_ack) begin
               cnt_inc = 1'b1;
               if (last_word) state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: begin
            line_refill = 1'b1;
            state_nxt   = S_RELEASE;
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Miss latches and word counter; counter wraps naturally at LINE_WORDS
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         miss_tag_l <= '0;
         miss_ent_l <= '0;
         way_l      <= '0;
      end else if (ld_miss) begin
         cnt        <= '0;
         miss_tag_l <= miss_tag;
         miss_ent_l <= miss_ent;
         way_l      <= way_replace_sel;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + OFS_WID'(1);
      end
   end

`ifdef CACHE_WBACK_EN
   logic [TAG_WID-1:0] victim_tag_l;

   always_ff @(posedge clk) begin
      if (rst)          victim_tag_l <= '0;
      else if (ld_miss) victim_tag_l <= victim_tag;
   end

   assign mem.mem_addr = we_c ? {victim_tag_l, miss_ent_l, cnt} : {miss_tag_l, miss_ent_l, cnt};
`else
   logic unused_wb;
   assign unused_wb    = ^{replace_dirty, victim_tag};
   assign mem.mem_addr = {miss_tag_l, miss_ent_l, cnt};
`endif

   assign mem.mem_req = req_c;
   assign mem.mem_we  = we_c;
   assign cache_way   = way_l;
   assign cache_word  = cnt;
   assign refill_tag  = miss_tag_l;

endmodule
